// File: rtl/pt_stream_pkg.sv
// Shared types and constants for the plaintext streamer.
// Defining PT_STREAM_HEADER_EN adds the HDR state used for the key/length header.
package pt_stream_pkg;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

`ifdef PT_STREAM_HEADER_EN
  typedef enum logic [2:0] {IDLE, RD_LEN, FETCH, SEND, HDR} state_e;
`else
  typedef enum logic [1:0] {IDLE, RD_LEN, FETCH, SEND} state_e;
`endif

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/pt_streamer_if.sv
// Byte stream from the plaintext streamer toward the UART/display path.
// A byte transfers on every rising clk edge where out_valid and out_ready are both 1;
// while out_valid=1 and out_ready=0 the master holds out_data/out_last unchanged.
interface pt_streamer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/pt_rd_delay.sv
// RD_LAT-deep valid shift register: ok_o rises RD_LAT cycles after a read
// request, i.e. exactly when the synchronous RAM data for that request is usable.
module pt_rd_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic ok_o
);

  logic [RD_LAT-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= RD_LAT'({sr_q, req_i});
  end

  assign ok_o = sr_q[RD_LAT-1];

endmodule

// File: rtl/pt_streamer.sv
// Reads a length-prefixed plaintext from RAM and streams its bytes, flagging non-printables.
// Optional PT_STREAM_HEADER_EN prefixes each run with key[23:0] and the length byte.
module pt_streamer
  import pt_stream_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic              key_valid,
  input  logic [23:0]       key,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [7:0]        pt_rddata,
  pt_streamer_if.master     out_if,
  output logic              bad_char,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic              bad_q, bad_d;
  logic              issued_q, issued_d;

  logic       accept;
  logic       rd_req;
  logic       rd_ok;
  logic [8:0] idx_p1;

  assign accept = (state_q == IDLE) && rdy_q && en;
  // One read request per RD_LEN/FETCH visit; issued_q blocks re-issue while waiting.
  assign rd_req = ((state_q == RD_LEN) || (state_q == FETCH)) && !issued_q;
  assign idx_p1 = 9'(idx_q) + 9'd1;

  pt_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (rd_req),
    .ok_o  (rd_ok)
  );

`ifdef PT_STREAM_HEADER_EN
  logic [23:0] key_q, key_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic        hdr_q, hdr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      hdr_cnt_q <= '0;
      hdr_q     <= 1'b0;
    end else begin
      key_q     <= key_d;
      hdr_cnt_q <= hdr_cnt_d;
      hdr_q     <= hdr_d;
    end
  end
`else
  logic unused_key;
  assign unused_key = ^key;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      len_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      bad_q    <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      last_q   <= last_d;
      bad_q    <= bad_d;
      issued_q <= issued_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    data_d   = data_q;
    last_d   = last_q;
    bad_d    = bad_q;
    issued_d = issued_q;
`ifdef PT_STREAM_HEADER_EN
    key_d     = key_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_d     = hdr_q;
`endif
    if (rd_req) issued_d = 1'b1;
    if (rd_ok)  issued_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          bad_d   = 1'b0;
          state_d = key_valid ? RD_LEN : IDLE;
`ifdef PT_STREAM_HEADER_EN
          key_d   = key;
`endif
        end
      end
      RD_LEN: begin
        if (rd_ok) begin
          len_d = pt_rddata;
`ifdef PT_STREAM_HEADER_EN
          data_d    = key_q[23:16];
          last_d    = 1'b0;
          hdr_d     = 1'b1;
          hdr_cnt_d = 2'd0;
          state_d   = SEND;
`else
          if (pt_rddata <= 8'd1) begin
            state_d = IDLE;
          end else begin
            idx_d   = ADDR_W'(1);
            state_d = FETCH;
          end
`endif
        end
      end
      FETCH: begin
        if (rd_ok) begin
          data_d  = pt_rddata;
          last_d  = (idx_p1 == {1'b0, len_q});
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_if.out_ready) begin
`ifdef PT_STREAM_HEADER_EN
          if (hdr_q) begin
            if (hdr_cnt_q == 2'd3) begin
              hdr_d = 1'b0;
              if (last_q) begin
                state_d = IDLE;
              end else begin
                idx_d   = ADDR_W'(1);
                state_d = FETCH;
              end
            end else begin
              hdr_cnt_d = hdr_cnt_q + 2'd1;
              state_d   = HDR;
            end
          end else
`endif
          begin
            if (!is_printable(data_q)) bad_d = 1'b1;
            if (last_q) begin
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = FETCH;
            end
          end
        end
      end
`ifdef PT_STREAM_HEADER_EN
      HDR: begin
        case (hdr_cnt_q)
          2'd1:    data_d = key_q[15:8];
          2'd2:    data_d = key_q[7:0];
          default: data_d = len_q;
        endcase
        // A run with no message bytes ends on the length byte.
        last_d  = (hdr_cnt_q == 2'd3) && (len_q <= 8'd1);
        state_d = SEND;
      end
`endif
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE) && !accept;
  end

  assign rdy              = rdy_q;
  assign pt_addr          = (state_q == FETCH) ? idx_q : '0;
  assign out_if.out_valid = (state_q == SEND);
  assign out_if.out_data  = data_q;
  assign out_if.out_last  = last_q && (state_q == SEND);
  assign bad_char         = bad_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_pt_streamer.sv
// Self-checking bench for pt_streamer: a RAM model, a handshake monitor and a
// message-level reference model that derives the expected stream from RAM contents.
module tb_pt_streamer;
  import pt_stream_pkg::*;

`ifdef PT_STREAM_HEADER_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 5;
`endif
  localparam int RUN_LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic        key_valid;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic        bad_char;
  state_e      dbg_state;

  pt_streamer_if sif();

  pt_streamer #(.ADDR_W(8), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key_valid (key_valid),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .out_if    (sif),
    .bad_char  (bad_char),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) pt_rddata <= mem[pt_addr];

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];   // {bad_char before handshake, last, data}
  logic [9:0] got_q[$];
  logic       exp_bad_end;
  int         checks = 0;
  int         errors = 0;
  int         negcnt = 0;
  int         en_neg = 0;
  int         first_lat = 0;
  bit         lat_seen = 1'b1;
  int         stall_viol = 0;
  int         overlap_viol = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;
  int         rmode = 0;
  int         busy_cycles;
  bit         timed_out;

  // Ready driver: 0 = always ready, 1 = toggle each cycle, other = random.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       sif.out_ready = 1'b1;
      1:       sif.out_ready = (sif.out_ready === 1'b1) ? 1'b0 : 1'b1;
      default: sif.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    negcnt++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (en && rdy) begin en_neg = negcnt; lat_seen = 1'b0; end
      if (sif.out_valid && !lat_seen) begin first_lat = negcnt - en_neg; lat_seen = 1'b1; end
      if (rdy && sif.out_valid) overlap_viol++;
      if (prev_stall && (!sif.out_valid || sif.out_data !== prev_d || sif.out_last !== prev_l))
        stall_viol++;
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_d = sif.out_data;
      prev_l = sif.out_last;
      if (sif.out_valid && sif.out_ready) got_q.push_back({bad_char, sif.out_last, sif.out_data});
    end
  end

  // ---------------- reference model ----------------
  function automatic void build_exp(input logic kv, input logic [23:0] k);
    int   len;
    logic bad;
    exp_q.delete();
    bad = 1'b0;
    exp_bad_end = 1'b0;
    if (!kv) return;
    len = int'(mem[0]);
`ifdef PT_STREAM_HEADER_EN
    exp_q.push_back({1'b0, 1'b0, k[23:16]});
    exp_q.push_back({1'b0, 1'b0, k[15:8]});
    exp_q.push_back({1'b0, 1'b0, k[7:0]});
    exp_q.push_back({1'b0, (len <= 1), mem[0]});
`endif
    for (int i = 1; i < len; i++) begin
      exp_q.push_back({bad, (i == len - 1), mem[i]});
      if (mem[i] < 8'h20 || mem[i] > 8'h7E) bad = 1'b1;
    end
    exp_bad_end = bad;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_msg(input logic kv, input logic [23:0] k);
    int n = 0;
    got_q.delete();
    build_exp(kv, k);
    @(posedge clk); #2;
    key_valid = kv; key = k; en = 1'b1;
    @(posedge clk); #2;
    en = 1'b0;
    while (rdy !== 1'b1 && n < RUN_LIMIT) begin @(posedge clk); #2; n++; end
    busy_cycles = n;
    timed_out = (n >= RUN_LIMIT);
  endtask

  task automatic fill_random(input int len, input int bad_pct);
    mem[0] = 8'(len);
    for (int i = 1; i < 256; i++)
      mem[i] = ($urandom_range(1, 100) <= bad_pct) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(32, 126));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; key_valid = 1'b0; key = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sif.out_valid); end
    checks++; if (sif.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", sif.out_last); end
    checks++; if (sif.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", sif.out_data); end
    checks++; if (pt_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", pt_addr); end
    checks++; if (bad_char !== 1'b0) begin errors++; $display("FAIL reset_bad: got %b want 0", bad_char); end
    rst_n = 1'b1;
    @(posedge clk); #2;
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_hi(input int mode, input string tag);
    mem[0] = 8'd5; mem[1] = 8'h48; mem[2] = 8'h69; mem[3] = 8'h21; mem[4] = 8'h21;
    rmode = mode;
    run_msg(1'b1, 24'h00ABCD);
    checks++; if (timed_out) begin errors++; $display("FAIL %s_timeout: got %0d cycles want < %0d", tag, busy_cycles, RUN_LIMIT); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d want %0d", tag, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_byte[%0d]: got %h want %h", tag, i, got_q[i], exp_q[i]); end
    end
    checks++; if (first_lat != EXP_LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", tag, first_lat, EXP_LAT); end
    checks++; if (bad_char !== 1'b0) begin errors++; $display("FAIL %s_bad: got %b want 0", tag, bad_char); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s_rdy: got %b want 1", tag, rdy); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL %s_stable: got %0d violations want 0", tag, stall_viol); end
    rmode = 0;
  endtask

  task automatic test_no_output();
    run_msg(1'b0, 24'h123456);
    checks++; if (busy_cycles != 1) begin errors++; $display("FAIL nokey_busy: got %0d want 1", busy_cycles); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL nokey_count: got %0d want 0", got_q.size()); end
    for (int l = 0; l < 2; l++) begin
      mem[0] = 8'(l);
      run_msg(1'b1, 24'h0F0F0F);
      checks++; if (timed_out) begin errors++; $display("FAIL short%0d_timeout: got %0d cycles", l, busy_cycles); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL short%0d_count: got %0d want %0d", l, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL short%0d_byte[%0d]: got %h want %h", l, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_bad_char();
    mem[0] = 8'd6; mem[1] = 8'h4F; mem[2] = 8'h0A; mem[3] = 8'h4B; mem[4] = 8'h7E; mem[5] = 8'h20;
    rmode = 2;
    run_msg(1'b1, 24'h000001);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bad_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bad_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bad_char !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b want 1", bad_char); end
    rmode = 0;
    run_msg(1'b0, 24'h0);
    checks++; if (bad_char !== 1'b0) begin errors++; $display("FAIL bad_clear: got %b want 0", bad_char); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mem[0] = 8'd7; mem[1] = 8'h01; mem[2] = 8'h41; mem[3] = 8'h42;
    mem[4] = 8'h43; mem[5] = 8'h44; mem[6] = 8'h45;
    rmode = 0;
    got_q.delete();
    @(posedge clk); #2;
    key_valid = 1'b1; key = 24'hC0FFEE; en = 1'b1;
    @(posedge clk); #2;
    en = 1'b0;
    while (got_q.size() < 1 && n < 200) begin @(posedge clk); #2; n++; end
    while (sif.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #2; n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL midrst_reach: got %0d cycles want < 200", n); end
    rst_n = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b want 1", rdy); end
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", sif.out_valid); end
    checks++; if (sif.out_last !== 1'b0) begin errors++; $display("FAIL midrst_last: got %b want 0", sif.out_last); end
    checks++; if (sif.out_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", sif.out_data); end
    checks++; if (pt_addr !== 8'h00) begin errors++; $display("FAIL midrst_addr: got %h want 00", pt_addr); end
    checks++; if (bad_char !== 1'b0) begin errors++; $display("FAIL midrst_bad: got %b want 0", bad_char); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_msg(1'b1, 24'hC0FFEE);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_rerun_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_rerun[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int          len;
      logic        kv;
      logic [23:0] k;
      len = (it % 6 == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 40));
      if (it == 23) len = 255;
      kv = ($urandom_range(0, 9) != 0);
      k = 24'($urandom);
      fill_random(len, 8);
      rmode = int'($urandom_range(0, 2));
      run_msg(kv, k);
      checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout: got %0d cycles", it, busy_cycles); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte[%0d]: got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
      checks++; if (bad_char !== exp_bad_end) begin errors++; $display("FAIL rnd%0d_bad: got %b want %b", it, bad_char, exp_bad_end); end
    end
    rmode = 0;
  endtask

`ifdef PT_STREAM_HEADER_EN
  task automatic test_header();
    mem[0] = 8'd3; mem[1] = 8'h41; mem[2] = 8'h42;
    run_msg(1'b1, 24'h1E4600);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL hdr_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL hdr_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
`endif

  task automatic test_invariants();
    checks++; if (overlap_viol != 0) begin errors++; $display("FAIL rdy_valid_overlap: got %0d want 0", overlap_viol); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d want 0", stall_viol); end
  endtask

  initial begin
    test_reset();
    test_hi(0, "hi");
    test_hi(1, "stall");
    test_no_output();
    test_bad_char();
    test_reset_mid();
`ifdef PT_STREAM_HEADER_EN
    test_header();
`endif
    test_random();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
